// File: rtl/bcd_count_scan.sv
// N-digit BCD up/down counter with tick prescaler and multiplexed 7-segment scan driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module bcd_count_scan #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned COUNT_DIV = 21,
  parameter int unsigned SCAN_DIV  = 17,
  parameter logic [23:0] PRESET    = 24'h000123
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  hold_end,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  tc,
  output logic                  done_pulse,
  output logic [2:0]            seg7_sel,
  output logic [6:0]            seg7_out,
  output logic                  dpt_out,
  output logic                  led_com
);

  localparam int unsigned W         = 4 * DIGITS;
  localparam logic [W-1:0] PresetVal = PRESET[W-1:0];
  localparam logic [2:0]   SelFirst  = 3'd5;
  localparam logic [2:0]   SelLast   = 3'(6 - DIGITS);

  logic [COUNT_DIV-1:0] tick_cnt_q, tick_cnt_d;
  logic [SCAN_DIV-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic [W-1:0]         count_q, count_d;
  logic [W-1:0]         reload_q, reload_d;
  logic                 done_q, done_d;
  logic                 tick, scan_step;
  logic                 all_nine, all_zero;

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple carry/borrow through the digits, units first.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick      = &tick_cnt_q;
  assign scan_step = &scan_cnt_q;
  assign all_nine  = (count_q == {DIGITS{4'h9}});
  assign all_zero  = (count_q == '0);
  assign tc        = up_down ? all_nine : all_zero;

  always_comb begin
    tick_cnt_d = load ? '0 : tick_cnt_q + 1'b1;
    scan_cnt_d = scan_cnt_q + 1'b1;
    sel_d      = sel_q;
    if (scan_step) begin
      sel_d = (sel_q == SelLast) ? SelFirst : sel_q - 3'd1;
    end
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      // Load wins outright; a coincident tick is dropped.
      count_d  = clamp_bcd(load_value);
      reload_d = clamp_bcd(load_value);
    end else if (tick && enable) begin
      if (tc) begin
        done_d = 1'b1;
        if (!hold_end) begin
          count_d = up_down ? '0 : reload_q;
        end
      end else begin
        count_d = bcd_step(count_q, up_down);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      sel_q      <= SelFirst;
      count_q    <= PresetVal;
      reload_q   <= PresetVal;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      done_q     <= done_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every digit above it are zero.
  logic [DIGITS-1:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run & (count_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      lead_zero[DIGITS-1-k] = run;
    end
  end
`endif

  logic [2:0] digit_idx;
  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    digit_idx = SelFirst - sel_q;
    cur_digit = 4'd0;
    blank     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx == 3'(i)) begin
        cur_digit = count_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (i != 0) && lead_zero[i];
`endif
      end
    end
    seg7_out = blank ? 7'b0000000 : seg_decode(cur_digit);
  end

  assign count_out  = count_q;
  assign done_pulse = done_q;
  assign seg7_sel   = sel_q;
  assign dpt_out    = 1'b0;
  assign led_com    = 1'b1;

endmodule

// File: tb/tb_bcd_count_scan.sv
// Scoreboard bench for bcd_count_scan with DIGITS=3, COUNT_DIV=2, SCAN_DIV=1 (tick every 4 clks).
module tb_bcd_count_scan;

  localparam int unsigned DIGITS = 3;
  localparam logic [6:0] Seg0   = 7'b1111110;
  localparam logic [6:0] Seg1   = 7'b0110000;
  localparam logic [6:0] Seg2   = 7'b1101101;
  localparam logic [6:0] Seg3   = 7'b1111001;
  localparam logic [6:0] Seg7   = 7'b1110000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        up_down = 1'b0;
  logic        hold_end = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_value = '0;
  logic [11:0] count_out;
  logic        tc;
  logic        done_pulse;
  logic [2:0]  seg7_sel;
  logic [6:0]  seg7_out;
  logic        dpt_out;
  logic        led_com;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic [11:0] count;
    logic        tc;
    logic        done;
  } cnt_exp_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
  } scan_exp_t;

  cnt_exp_t  cnt_q[$];
  scan_exp_t scan_q[$];

  bcd_count_scan #(
    .DIGITS    (DIGITS),
    .COUNT_DIV (2),
    .SCAN_DIV  (1),
    .PRESET    (24'h000123)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .hold_end   (hold_end),
    .load       (load),
    .load_value (load_value),
    .count_out  (count_out),
    .tc         (tc),
    .done_pulse (done_pulse),
    .seg7_sel   (seg7_sel),
    .seg7_out   (seg7_out),
    .dpt_out    (dpt_out),
    .led_com    (led_com)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic do_load(input logic [11:0] v);
    load       = 1'b1;
    load_value = v;
    @(posedge clk);
    #1;
    load       = 1'b0;
    load_value = '0;
  endtask

  // Expected select for the k-th edge after reset release: 5,5,4,4,3,3,5,...
  function automatic logic [2:0] exp_sel(input int k);
    case ((k / 2) % 3)
      0:       return 3'd5;
      1:       return 3'd4;
      default: return 3'd3;
    endcase
  endfunction

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (count_out !== 12'h123) $display("FAIL reset.count: got %h want 123", count_out); else n_pass++;
    n_checks++; if (seg7_sel !== 3'd5) $display("FAIL reset.sel: got %0d want 5", seg7_sel); else n_pass++;
    n_checks++; if (done_pulse !== 1'b0) $display("FAIL reset.done: got %b want 0", done_pulse); else n_pass++;
    n_checks++; if (tc !== 1'b0) $display("FAIL reset.tc: got %b want 0", tc); else n_pass++;
    n_checks++; if (seg7_out !== Seg3) $display("FAIL reset.seg: got %b want %b", seg7_out, Seg3); else n_pass++;
    n_checks++; if (dpt_out !== 1'b0 || led_com !== 1'b1)
      $display("FAIL reset.const: got dpt=%b com=%b want 0/1", dpt_out, led_com); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_count_down();
    cnt_exp_t e;
    up_down = 1'b0;
    enable  = 1'b1;
    cnt_q.push_back('{count: 12'h122, tc: 1'b0, done: 1'b0});
    cnt_q.push_back('{count: 12'h121, tc: 1'b0, done: 1'b0});
    cnt_q.push_back('{count: 12'h120, tc: 1'b0, done: 1'b0});
    cnt_q.push_back('{count: 12'h119, tc: 1'b0, done: 1'b0});
    while (cnt_q.size() != 0) begin
      repeat (4) @(posedge clk);
      #1;
      e = cnt_q.pop_front();
      n_checks++; if (count_out !== e.count)
        $display("FAIL count_down.count: got %h want %h", count_out, e.count); else n_pass++;
      n_checks++; if (done_pulse !== e.done)
        $display("FAIL count_down.done: got %b want %b", done_pulse, e.done); else n_pass++;
    end
  endtask

  task automatic test_load_wrap_down();
    cnt_exp_t e;
    up_down  = 1'b0;
    hold_end = 1'b0;
    do_load(12'h001);
    n_checks++; if (count_out !== 12'h001)
      $display("FAIL wrap_down.load: got %h want 001", count_out); else n_pass++;
    cnt_q.push_back('{count: 12'h000, tc: 1'b1, done: 1'b0});
    cnt_q.push_back('{count: 12'h001, tc: 1'b0, done: 1'b1});
    while (cnt_q.size() != 0) begin
      repeat (4) @(posedge clk);
      #1;
      e = cnt_q.pop_front();
      n_checks++; if (count_out !== e.count)
        $display("FAIL wrap_down.count: got %h want %h", count_out, e.count); else n_pass++;
      n_checks++; if (tc !== e.tc)
        $display("FAIL wrap_down.tc: got %b want %b", tc, e.tc); else n_pass++;
      n_checks++; if (done_pulse !== e.done)
        $display("FAIL wrap_down.done: got %b want %b", done_pulse, e.done); else n_pass++;
    end
    @(posedge clk);
    #1;
    n_checks++; if (done_pulse !== 1'b0)
      $display("FAIL wrap_down.pulse_width: got %b want 0", done_pulse); else n_pass++;
  endtask

  task automatic test_hold_up();
    cnt_exp_t e;
    up_down  = 1'b1;
    hold_end = 1'b1;
    do_load(12'h998);
    cnt_q.push_back('{count: 12'h999, tc: 1'b1, done: 1'b0});
    cnt_q.push_back('{count: 12'h999, tc: 1'b1, done: 1'b1});
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        hold_end = 1'b0;
        cnt_q.push_back('{count: 12'h000, tc: 1'b0, done: 1'b1});
      end
      while (cnt_q.size() != 0) begin
        repeat (4) @(posedge clk);
        #1;
        e = cnt_q.pop_front();
        n_checks++; if (count_out !== e.count)
          $display("FAIL hold_up.count: got %h want %h", count_out, e.count); else n_pass++;
        n_checks++; if (tc !== e.tc)
          $display("FAIL hold_up.tc: got %b want %b", tc, e.tc); else n_pass++;
        n_checks++; if (done_pulse !== e.done)
          $display("FAIL hold_up.done: got %b want %b", done_pulse, e.done); else n_pass++;
      end
    end
    up_down = 1'b0;
    #1;
    n_checks++; if (tc !== 1'b1) $display("FAIL dir_change.tc_down: got %b want 1", tc); else n_pass++;
    up_down = 1'b1;
    #1;
    n_checks++; if (tc !== 1'b0) $display("FAIL dir_change.tc_up: got %b want 0", tc); else n_pass++;
  endtask

  task automatic test_enable_and_load_tick();
    int unsigned bad;
    up_down = 1'b0;
    enable  = 1'b0;
    do_load(12'h045);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (count_out !== 12'h045 || done_pulse !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0)
      $display("FAIL enable_off.frozen: got %0d bad cycles, last %h want 045 no pulse", bad, count_out);
    else n_pass++;
    enable = 1'b1;
    do_load(12'h5A2);
    n_checks++; if (count_out !== 12'h592)
      $display("FAIL load_tick.count: got %h want 592", count_out); else n_pass++;
    n_checks++; if (done_pulse !== 1'b0)
      $display("FAIL load_tick.done: got %b want 0", done_pulse); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (count_out !== 12'h592)
      $display("FAIL load_tick.prescale_clear: got %h want 592", count_out); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (count_out !== 12'h591)
      $display("FAIL load_tick.first_step: got %h want 591", count_out); else n_pass++;
  endtask

  task automatic test_scan();
    scan_exp_t e;
    logic [6:0] s;
    enable = 1'b0;
    reset  = 1'b0;
    #1;
    n_checks++; if (count_out !== 12'h123)
      $display("FAIL scan.reset_count: got %h want 123", count_out); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    do_load(12'h120);
    for (int k = 1; k <= 14; k++) begin
      case (exp_sel(k))
        3'd5:    s = Seg0;
        3'd4:    s = Seg2;
        default: s = Seg1;
      endcase
      scan_q.push_back('{sel: exp_sel(k), seg: s});
    end
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      e = scan_q.pop_front();
      n_checks++; if (seg7_sel !== e.sel || seg7_out !== e.seg)
        $display("FAIL scan.step%0d: got sel=%0d seg=%b want sel=%0d seg=%b",
                 k, seg7_sel, seg7_out, e.sel, e.seg);
      else n_pass++;
    end
    #3 reset = 1'b0;
    #1;
    n_checks++; if (seg7_sel !== 3'd5 || count_out !== 12'h123)
      $display("FAIL scan.async_reset: got sel=%0d count=%h want sel=5 count=123",
               seg7_sel, count_out);
    else n_pass++;
  endtask

  task automatic test_blank();
    scan_exp_t e;
    logic [6:0] units_seg;
    logic [6:0] upper_seg;
`ifdef LEADING_ZERO_BLANK_EN
    upper_seg = 7'b0000000;
`else
    upper_seg = Seg0;
`endif
    @(negedge clk);
    reset = 1'b1;
    do_load(12'h007);
    n_checks++; if (count_out !== 12'h007 || tc !== 1'b0)
      $display("FAIL blank.count: got %h tc=%b want 007 tc=0", count_out, tc); else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      if (k == 7) begin
        do_load(12'h000);
      end else if (k > 1) begin
        @(posedge clk);
        #1;
      end
      units_seg = (k < 7) ? Seg7 : Seg0;
      scan_q.push_back('{sel: exp_sel(k), seg: (exp_sel(k) == 3'd5) ? units_seg : upper_seg});
      e = scan_q.pop_front();
      n_checks++; if (seg7_sel !== e.sel || seg7_out !== e.seg)
        $display("FAIL blank.step%0d: got sel=%0d seg=%b want sel=%0d seg=%b",
                 k, seg7_sel, seg7_out, e.sel, e.seg);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_load_wrap_down();
    test_hold_up();
    test_enable_and_load_tick();
    test_scan();
    test_blank();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
